// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: core register geometry,
// write-source encoding and the per-cycle source selection rule.
package wb_arbiter_pkg;

  // Core-wide register file geometry shared with the rest of the pipeline.
  localparam int CORE_REG_WIDTH      = 32;
  localparam int CORE_REG_ADDR_WIDTH = 5;

  // Which result (if any) drives the register-file write this cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LD   = 2'd2
  } wb_src_e;

  // The load FIFO wins when it is full (so loads cannot starve) or when the
  // ALU has nothing to offer; otherwise the ALU result goes first.
  function automatic wb_src_e wb_select(input logic fifo_full,
                                        input logic fifo_empty,
                                        input logic alu_valid);
    wb_src_e src;
    if (fifo_full || !alu_valid) begin
      if (!fifo_empty) begin
        src = WB_SRC_LD;
      end else begin
        src = WB_SRC_NONE;
      end
    end else begin
      src = WB_SRC_ALU;
    end
    return src;
  endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// Load-result FIFO: synchronous, first-word fall-through (the head entry is
// visible on pop_data whenever empty is low), with full and empty flags.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module wb_ld_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Advance read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load results onto the single register
// file write port, buffers loads in a small FIFO, and keeps a per-register
// busy scoreboard for issue-time hazard checks.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int REG_WIDTH      = CORE_REG_WIDTH,
  parameter int REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH,
  parameter int LD_DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]      alu_data,
  output logic                      alu_ready,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [REG_WIDTH-1:0]      ld_data,
  output logic                      ld_ready,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_w_addr,
  output logic [REG_WIDTH-1:0]      reg_w_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int LD_WIDTH = REG_ADDR_WIDTH + REG_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO   = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [REG_WIDTH-1:0]      DATA_ZERO = {REG_WIDTH{1'b0}};
  localparam logic [NUM_REGS-1:0]       MASK_ZERO = {NUM_REGS{1'b0}};
  localparam logic [NUM_REGS-1:0]       BIT0_MASK = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Scoreboard
  logic [NUM_REGS-1:0]       busy_r;
  logic [NUM_REGS-1:0]       busy_nxt_s;
  logic [NUM_REGS-1:0]       set_mask_s;
  logic [NUM_REGS-1:0]       clr_mask_s;

  // Load FIFO
  logic                      fifo_push_s;
  logic                      fifo_pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [LD_WIDTH-1:0]       fifo_head_s;
  logic                      accept_s;

  // Selection
  wb_src_e                   src_s;
  logic                      sel_valid_s;
  logic [REG_ADDR_WIDTH-1:0] sel_rd_s;
  logic [REG_WIDTH-1:0]      sel_data_s;

  // Output register
  logic                      reg_wen_r;
  logic [REG_ADDR_WIDTH-1:0] reg_w_addr_r;
  logic [REG_WIDTH-1:0]      reg_w_data_r;

  // Both producers are held off while reset is asserted; outside reset they
  // can be accepted whenever the load FIFO has room (the ALU is only
  // selected in exactly that case).
  assign accept_s    = rst_n & ~fifo_full_s;
  assign alu_ready   = accept_s;
  assign ld_ready    = accept_s;
  assign fifo_push_s = ld_valid & accept_s;

  wb_ld_fifo #(
    .WIDTH (LD_WIDTH),
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_s),
    .push_data ({ld_rd, ld_data}),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Pick this cycle's write candidate and pop the FIFO head when it is chosen.
  always_comb begin
    src_s       = wb_select(fifo_full_s, fifo_empty_s, alu_valid);
    sel_valid_s = 1'b0;
    sel_rd_s    = RD_ZERO;
    sel_data_s  = DATA_ZERO;
    fifo_pop_s  = 1'b0;
    case (src_s)
      WB_SRC_ALU: begin
        sel_valid_s = 1'b1;
        sel_rd_s    = alu_rd;
        sel_data_s  = alu_data;
      end
      WB_SRC_LD: begin
        sel_valid_s = 1'b1;
        sel_rd_s    = fifo_head_s[LD_WIDTH-1:REG_WIDTH];
        sel_data_s  = fifo_head_s[REG_WIDTH-1:0];
        fifo_pop_s  = 1'b1;
      end
      WB_SRC_NONE: begin
        sel_valid_s = 1'b0;
      end
      default: begin
        sel_valid_s = 1'b0;
      end
    endcase
  end

  // Register the selected result; x0 results complete silently and the
  // address/data outputs keep their previous values whenever no write occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wen_r    <= 1'b0;
      reg_w_addr_r <= RD_ZERO;
      reg_w_data_r <= DATA_ZERO;
    end else begin
      if (sel_valid_s && (sel_rd_s != RD_ZERO)) begin
        reg_wen_r    <= 1'b1;
        reg_w_addr_r <= sel_rd_s;
        reg_w_data_r <= sel_data_s;
      end else begin
        reg_wen_r    <= 1'b0;
      end
    end
  end

  // Next busy vector: clear the register being written, then apply the
  // issue so a same-cycle set wins; register 0 is never marked busy.
  always_comb begin
    set_mask_s = MASK_ZERO;
    clr_mask_s = MASK_ZERO;
    if (iss_valid && (iss_rd != RD_ZERO)) begin
      set_mask_s = BIT0_MASK << iss_rd;
    end else begin
      set_mask_s = MASK_ZERO;
    end
    if (reg_wen_r) begin
      clr_mask_s = BIT0_MASK << reg_w_addr_r;
    end else begin
      clr_mask_s = MASK_ZERO;
    end
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~BIT0_MASK;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= MASK_ZERO;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rs1_busy   = (rs1_addr != RD_ZERO) & busy_r[rs1_addr];
  assign rs2_busy   = (rs2_addr != RD_ZERO) & busy_r[rs2_addr];
  assign reg_wen    = reg_wen_r;
  assign reg_w_addr = reg_w_addr_r;
  assign reg_w_data = reg_w_data_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter with a queue-based reference model.
module tb_wb_arbiter;

  localparam int RW       = 32;
  localparam int AW       = 5;
  localparam int LD_DEPTH = 2;
  localparam int NREG     = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [RW-1:0] alu_data;
  logic          alu_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_rd;
  logic [RW-1:0] ld_data;
  logic          ld_ready;
  logic          reg_wen;
  logic [AW-1:0] reg_w_addr;
  logic [RW-1:0] reg_w_data;

  always #5 clk = ~clk;

  wb_arbiter #(
    .REG_WIDTH      (RW),
    .REG_ADDR_WIDTH (AW),
    .LD_DEPTH       (LD_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .reg_wen    (reg_wen),
    .reg_w_addr (reg_w_addr),
    .reg_w_data (reg_w_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: busy set, pending-load queue, and the write port state.
  bit                 mbusy [NREG];
  logic [AW+RW-1:0]   mq [$];
  logic               m_wen;
  logic [AW-1:0]      m_addr;
  logic [RW-1:0]      m_data;

  // Per-step expected and observed values.
  logic e_alu_ready, e_ld_ready, e_rs1, e_rs2;
  logic o_alu_ready, o_ld_ready, o_rs1, o_rs2;
  logic o_wen;
  logic [AW-1:0] o_addr;
  logic [RW-1:0] o_data;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mbusy[i] = 1'b0;
    mq.delete();
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic drive_idle();
    iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  // One clock cycle. Called just after a falling edge with inputs applied.
  // Samples the combinational outputs, advances the model by the rules of
  // the arbiter, then samples the registered outputs after the rising edge.
  task automatic step();
    logic             sel_v;
    logic [AW-1:0]    sel_rd;
    logic [RW-1:0]    sel_d;
    logic [AW+RW-1:0] head;
    bit               push;
    #1;
    e_alu_ready = (mq.size() < LD_DEPTH);
    e_ld_ready  = (mq.size() < LD_DEPTH);
    e_rs1       = (rs1_addr != 0) && mbusy[rs1_addr];
    e_rs2       = (rs2_addr != 0) && mbusy[rs2_addr];
    o_alu_ready = alu_ready;
    o_ld_ready  = ld_ready;
    o_rs1       = rs1_busy;
    o_rs2       = rs2_busy;
    push  = ld_valid && (mq.size() < LD_DEPTH);
    sel_v = 1'b0; sel_rd = '0; sel_d = '0;
    if (mq.size() == LD_DEPTH || !alu_valid) begin
      if (mq.size() > 0) begin
        head   = mq.pop_front();
        sel_v  = 1'b1;
        sel_rd = head[AW+RW-1:RW];
        sel_d  = head[RW-1:0];
      end
    end else begin
      sel_v = 1'b1; sel_rd = alu_rd; sel_d = alu_data;
    end
    if (push) mq.push_back({ld_rd, ld_data});
    if (m_wen) mbusy[m_addr] = 1'b0;
    if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    if (sel_v && sel_rd != 0) begin
      m_wen = 1'b1; m_addr = sel_rd; m_data = sel_d;
    end else begin
      m_wen = 1'b0;
    end
    @(posedge clk);
    #1;
    o_wen  = reg_wen;
    o_addr = reg_w_addr;
    o_data = reg_w_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (reg_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", reg_wen); end
    checks++; if (reg_w_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", reg_w_addr); end
    checks++; if (reg_w_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", reg_w_data); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL release_alu_ready: got %b want 1", alu_ready); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL release_ld_ready: got %b want 1", ld_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_alu();
    drive_idle();
    iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5;
    step();
    checks++; if (o_rs1 !== 1'b0) begin errors++; $display("FAIL single_busy_pre: got %b want 0", o_rs1); end
    drive_idle();
    rs1_addr = 5'd5; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    checks++; if (o_rs1 !== 1'b1) begin errors++; $display("FAIL single_busy_set: got %b want 1", o_rs1); end
    checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b want 1", o_alu_ready); end
    checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL single_wen: got %b want 1", o_wen); end
    checks++; if (o_addr !== 5'd5) begin errors++; $display("FAIL single_addr: got %0d want 5", o_addr); end
    checks++; if (o_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", o_data); end
    drive_idle();
    rs1_addr = 5'd5;
    step();
    checks++; if (o_rs1 !== 1'b1) begin errors++; $display("FAIL single_busy_during_write: got %b want 1", o_rs1); end
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL single_wen_drop: got %b want 0", o_wen); end
    checks++; if (o_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_hold: got %h want deadbeef", o_data); end
    step();
    checks++; if (o_rs1 !== 1'b0) begin errors++; $display("FAIL single_busy_clear: got %b want 0", o_rs1); end
  endtask

  task automatic test_x0();
    drive_idle();
    iss_valid = 1'b1; iss_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    step();
    checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready: got %b want 1", o_alu_ready); end
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL x0_wen: got %b want 0", o_wen); end
    checks++; if (o_addr !== m_addr) begin errors++; $display("FAIL x0_addr_hold: got %0d want %0d", o_addr, m_addr); end
    drive_idle();
    step();
    checks++; if (o_rs1 !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", o_rs1); end
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL x0_wen_late: got %b want 0", o_wen); end
  endtask

  task automatic test_set_clear();
    drive_idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777;
    step();
    checks++; if (o_wen !== 1'b1 || o_addr !== 5'd7) begin errors++; $display("FAIL setclr_write: got wen=%b addr=%0d want 1/7", o_wen, o_addr); end
    drive_idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    drive_idle();
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    step();
    checks++; if (o_rs1 !== 1'b1) begin errors++; $display("FAIL setclr_busy: got %b want 1", o_rs1); end
    checks++; if (o_rs2 !== e_rs2) begin errors++; $display("FAIL setclr_busy_rs2: got %b want %b", o_rs2, e_rs2); end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 12; i++) begin
      drive_idle();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = $urandom;
      ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = $urandom;
      step();
      checks++; if (o_alu_ready !== e_alu_ready) begin errors++; $display("FAIL cont_alu_ready cyc %0d: got %b want %b", i, o_alu_ready, e_alu_ready); end
      checks++; if (o_ld_ready !== e_ld_ready) begin errors++; $display("FAIL cont_ld_ready cyc %0d: got %b want %b", i, o_ld_ready, e_ld_ready); end
      checks++; if (o_wen !== m_wen || o_addr !== m_addr || o_data !== m_data) begin
        errors++; $display("FAIL cont_write cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, o_wen, o_addr, o_data, m_wen, m_addr, m_data);
      end
      if (i == 2) begin
        checks++; if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL cont_full_ld_ready: got %b want 0", o_ld_ready); end
        checks++; if (o_addr !== 5'd4) begin errors++; $display("FAIL cont_load_slot: got addr %0d want 4", o_addr); end
      end
    end
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (o_wen !== m_wen || o_addr !== m_addr || o_data !== m_data) begin
        errors++; $display("FAIL cont_drain step %0d: got %b/%0d/%h want %b/%0d/%h", i, o_wen, o_addr, o_data, m_wen, m_addr, m_data);
      end
    end
    checks++; if (mq.size() != 0) begin errors++; $display("FAIL cont_model_drain: got %0d want 0", mq.size()); end
  endtask

  task automatic test_wrap();
    logic [RW-1:0] sent [10];
    int nwr;
    nwr = 0;
    for (int i = 0; i < 13; i++) begin
      drive_idle();
      if (i < 10) begin
        sent[i]  = $urandom;
        ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = sent[i];
      end
      step();
      checks++; if (o_ld_ready !== e_ld_ready) begin errors++; $display("FAIL wrap_ld_ready cyc %0d: got %b want %b", i, o_ld_ready, e_ld_ready); end
      if (o_wen === 1'b1) begin
        checks++;
        if (nwr >= 10 || o_addr !== 5'(nwr + 1) || o_data !== sent[nwr]) begin
          errors++; $display("FAIL wrap_order write %0d: got %0d/%h", nwr, o_addr, o_data);
        end
        nwr++;
      end
      if (i >= 1 && i <= 10) begin
        checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL wrap_rate cyc %0d: got wen %b want 1", i, o_wen); end
      end
    end
    checks++; if (nwr != 10) begin errors++; $display("FAIL wrap_count: got %0d want 10", nwr); end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(9 + i);
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = $urandom;
      ld_valid  = 1'b1; ld_rd  = 5'd13; ld_data  = $urandom;
      step();
    end
    checks++; if (mq.size() != 2) begin errors++; $display("FAIL mid_prefill: got %0d want 2", mq.size()); end
    drive_idle();
    rst_n = 1'b0;
    #1;
    checks++; if (reg_wen !== 1'b0) begin errors++; $display("FAIL mid_wen: got %b want 0", reg_wen); end
    checks++; if (ld_ready !== 1'b0 || alu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b/%b want 0/0", alu_ready, ld_ready); end
    for (int r = 0; r < NREG; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(NREG - 1 - r);
      #1;
      checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL mid_busy reg %0d: got %b/%b want 0/0", r, rs1_busy, rs2_busy); end
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL mid_no_write step %0d: got %b want 0", i, o_wen); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 31));
      rs1_addr  = 5'($urandom_range(0, 31));
      rs2_addr  = 5'($urandom_range(0, 31));
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 9) < 5);
      ld_rd     = 5'($urandom_range(0, 31));
      ld_data   = $urandom;
      step();
      checks++; if (o_alu_ready !== e_alu_ready) begin errors++; $display("FAIL rnd_alu_ready cyc %0d: got %b want %b", i, o_alu_ready, e_alu_ready); end
      checks++; if (o_ld_ready !== e_ld_ready) begin errors++; $display("FAIL rnd_ld_ready cyc %0d: got %b want %b", i, o_ld_ready, e_ld_ready); end
      checks++; if (o_rs1 !== e_rs1) begin errors++; $display("FAIL rnd_rs1_busy cyc %0d: got %b want %b", i, o_rs1, e_rs1); end
      checks++; if (o_rs2 !== e_rs2) begin errors++; $display("FAIL rnd_rs2_busy cyc %0d: got %b want %b", i, o_rs2, e_rs2); end
      checks++; if (o_wen !== m_wen) begin errors++; $display("FAIL rnd_wen cyc %0d: got %b want %b", i, o_wen, m_wen); end
      checks++; if (o_addr !== m_addr || o_data !== m_data) begin
        errors++; $display("FAIL rnd_wdata cyc %0d: got %0d/%h want %0d/%h", i, o_addr, o_data, m_addr, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_x0();
    test_set_clear();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
